// File: rtl/bus_arbiter.sv
// Two-port data bus arbiter: instruction fetch (m0) and load/store unit (m1) share one bus.
// LSU wins ties unless fetch has been passed over STARVE_LIMIT times; all outputs are registered.
module bus_arbiter #(
  parameter int unsigned WAIT_STATES  = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  output logic        m0_exc,
  input  logic        m1_req,
  input  logic        m1_rw,
  input  logic [1:0]  m1_len,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        m1_exc,
  output logic        bus_rw,
  output logic [1:0]  bus_len,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_write,
  input  logic [31:0] bus_read,
  input  logic        bus_exception
);

  localparam logic [3:0] WAIT_LOAD   = 4'(WAIT_STATES);
  localparam logic [3:0] STARVE_MAX  = 4'(STARVE_LIMIT);
  localparam logic [1:0] LEN_WORD    = 2'd2;
  localparam logic [1:0] LEN_ILLEGAL = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        owner, owner_nxt;          // 0 = fetch, 1 = LSU
  logic [3:0]  wait_cnt, wait_nxt;
  logic [3:0]  starve_cnt, starve_nxt;
  logic        pick_m0, pick_m1, last_wait;

  logic        m0_gnt_nxt, m0_done_nxt, m0_exc_nxt;
  logic        m1_gnt_nxt, m1_done_nxt, m1_exc_nxt;
  logic [31:0] m0_rdata_nxt, m1_rdata_nxt;
  logic        bus_rw_nxt;
  logic [1:0]  bus_len_nxt;
  logic [31:0] bus_addr_nxt, bus_write_nxt;

  always_comb begin
    pick_m0   = m0_req && (!m1_req || (starve_cnt == STARVE_MAX));
    pick_m1   = m1_req && !pick_m0;
    last_wait = (wait_cnt <= 4'd1);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (pick_m0)      state_nxt = ACCESS;
        else if (pick_m1) state_nxt = (m1_len == LEN_ILLEGAL) ? DONE : ACCESS;
      end
      ACCESS:  if (last_wait) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values for every registered output and counter
  always_comb begin
    owner_nxt     = owner;
    wait_nxt      = wait_cnt;
    starve_nxt    = starve_cnt;
    m0_gnt_nxt    = 1'b0;
    m0_done_nxt   = 1'b0;
    m0_exc_nxt    = m0_exc;
    m0_rdata_nxt  = m0_rdata;
    m1_gnt_nxt    = 1'b0;
    m1_done_nxt   = 1'b0;
    m1_exc_nxt    = m1_exc;
    m1_rdata_nxt  = m1_rdata;
    bus_rw_nxt    = bus_rw;
    bus_len_nxt   = bus_len;
    bus_addr_nxt  = bus_addr;
    bus_write_nxt = bus_write;
    case (state)
      IDLE: begin
        if (pick_m0) begin
          owner_nxt     = 1'b0;
          m0_gnt_nxt    = 1'b1;
          starve_nxt    = 4'd0;
          wait_nxt      = WAIT_LOAD;
          bus_rw_nxt    = 1'b0;
          bus_len_nxt   = LEN_WORD;
          bus_addr_nxt  = m0_addr;
          bus_write_nxt = 32'd0;
        end else if (pick_m1) begin
          owner_nxt  = 1'b1;
          m1_gnt_nxt = 1'b1;
          if (m0_req && (starve_cnt < STARVE_MAX)) starve_nxt = starve_cnt + 4'd1;
          // Illegal length is rejected without touching the bus
          if (m1_len == LEN_ILLEGAL) begin
            m1_exc_nxt   = 1'b1;
            m1_rdata_nxt = 32'd0;
          end else begin
            wait_nxt      = WAIT_LOAD;
            bus_rw_nxt    = m1_rw;
            bus_len_nxt   = m1_len;
            bus_addr_nxt  = m1_addr;
            bus_write_nxt = m1_wdata;
          end
        end
      end
      ACCESS: begin
        wait_nxt = wait_cnt - 4'd1;
        if (last_wait) begin
          wait_nxt = 4'd0;
          if (owner) begin
            m1_rdata_nxt = bus_read;
            m1_exc_nxt   = bus_exception;
          end else begin
            m0_rdata_nxt = bus_read;
            m0_exc_nxt   = bus_exception;
          end
          bus_rw_nxt    = 1'b0;
          bus_len_nxt   = 2'd0;
          bus_addr_nxt  = 32'd0;
          bus_write_nxt = 32'd0;
        end
      end
      DONE: begin
        if (owner) m1_done_nxt = 1'b1;
        else       m0_done_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner      <= 1'b0;
      wait_cnt   <= 4'd0;
      starve_cnt <= 4'd0;
      m0_gnt     <= 1'b0;
      m0_done    <= 1'b0;
      m0_exc     <= 1'b0;
      m0_rdata   <= 32'd0;
      m1_gnt     <= 1'b0;
      m1_done    <= 1'b0;
      m1_exc     <= 1'b0;
      m1_rdata   <= 32'd0;
      bus_rw     <= 1'b0;
      bus_len    <= 2'd0;
      bus_addr   <= 32'd0;
      bus_write  <= 32'd0;
    end else begin
      owner      <= owner_nxt;
      wait_cnt   <= wait_nxt;
      starve_cnt <= starve_nxt;
      m0_gnt     <= m0_gnt_nxt;
      m0_done    <= m0_done_nxt;
      m0_exc     <= m0_exc_nxt;
      m0_rdata   <= m0_rdata_nxt;
      m1_gnt     <= m1_gnt_nxt;
      m1_done    <= m1_done_nxt;
      m1_exc     <= m1_exc_nxt;
      m1_rdata   <= m1_rdata_nxt;
      bus_rw     <= bus_rw_nxt;
      bus_len    <= bus_len_nxt;
      bus_addr   <= bus_addr_nxt;
      bus_write  <= bus_write_nxt;
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: instance a uses WAIT_STATES=1, instance b WAIT_STATES=3.
module tb_bus_arbiter;

  logic        clk;
  logic        rst_a, rst_b;
  logic        m0_req, m1_req, b_m0_req, b_m1_req;
  logic [31:0] m0_addr, m1_addr, m1_wdata, bus_read;
  logic        m1_rw, bus_exception;
  logic [1:0]  m1_len;

  logic        m0_gnt, m0_done, m0_exc, m1_gnt, m1_done, m1_exc, bus_rw;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_write;
  logic [1:0]  bus_len;

  logic        b_m0_gnt, b_m0_done, b_m0_exc, b_m1_gnt, b_m1_done, b_m1_exc, b_bus_rw;
  logic [31:0] b_m0_rdata, b_m1_rdata, b_bus_addr, b_bus_write;
  logic [1:0]  b_bus_len;

  int n_checks = 0;
  int n_errors = 0;

  bus_arbiter #(.WAIT_STATES(1), .STARVE_LIMIT(4)) u_dut_a (
    .clk(clk), .reset_n(rst_a),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_gnt(m0_gnt), .m0_done(m0_done),
    .m0_rdata(m0_rdata), .m0_exc(m0_exc),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_len(m1_len), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_done(m1_done),
    .m1_rdata(m1_rdata), .m1_exc(m1_exc),
    .bus_rw(bus_rw), .bus_len(bus_len), .bus_addr(bus_addr), .bus_write(bus_write),
    .bus_read(bus_read), .bus_exception(bus_exception)
  );

  bus_arbiter #(.WAIT_STATES(3), .STARVE_LIMIT(4)) u_dut_b (
    .clk(clk), .reset_n(rst_b),
    .m0_req(b_m0_req), .m0_addr(m0_addr), .m0_gnt(b_m0_gnt), .m0_done(b_m0_done),
    .m0_rdata(b_m0_rdata), .m0_exc(b_m0_exc),
    .m1_req(b_m1_req), .m1_rw(m1_rw), .m1_len(m1_len), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(b_m1_gnt), .m1_done(b_m1_done),
    .m1_rdata(b_m1_rdata), .m1_exc(b_m1_exc),
    .bus_rw(b_bus_rw), .bus_len(b_bus_len), .bus_addr(b_bus_addr), .bus_write(b_bus_write),
    .bus_read(bus_read), .bus_exception(bus_exception)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] seq [6];
  logic [1:0] exp_seq [6];
  int         ng;
  int         b_done_seen;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; b_m0_req = 1'b0; b_m1_req = 1'b0;
    m0_addr = 32'd0; m1_addr = 32'd0; m1_wdata = 32'd0; m1_rw = 1'b0; m1_len = 2'd0;
    bus_read = 32'd0; bus_exception = 1'b0;
    exp_seq = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b10};
    repeat (3) step();
    rst_a = 1'b1; rst_b = 1'b1;
    step();

    // Reset state
    check("rst_m0_gnt", 32'(m0_gnt), 32'd0);
    check("rst_m1_done", 32'(m1_done), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_len", 32'(bus_len), 32'd0);
    check("rst_m0_rdata", m0_rdata, 32'd0);

    // Single fetch
    m0_req = 1'b1; m0_addr = 32'h0000_0100; bus_read = 32'h1234_5678;
    step();
    check("f_gnt", 32'(m0_gnt), 32'd1);
    check("f_m1_gnt", 32'(m1_gnt), 32'd0);
    check("f_bus_addr", bus_addr, 32'h100);
    check("f_bus_len", 32'(bus_len), 32'd2);
    check("f_bus_rw", 32'(bus_rw), 32'd0);
    m0_req = 1'b0; m0_addr = 32'h0000_0DEF;
    step();
    check("f_gnt_pulse", 32'(m0_gnt), 32'd0);
    check("f_bus_idle", bus_addr, 32'd0);
    check("f_done_early", 32'(m0_done), 32'd0);
    check("f_rdata", m0_rdata, 32'h1234_5678);
    step();
    check("f_done", 32'(m0_done), 32'd1);
    check("f_exc", 32'(m0_exc), 32'd0);
    check("f_m1_done", 32'(m1_done), 32'd0);
    step();
    check("f_done_pulse", 32'(m0_done), 32'd0);

    // LSU word write
    m1_req = 1'b1; m1_rw = 1'b1; m1_len = 2'd2; m1_addr = 32'h0000_F000; m1_wdata = 32'h0000_00A5;
    step();
    check("w_gnt", 32'(m1_gnt), 32'd1);
    check("w_bus_rw", 32'(bus_rw), 32'd1);
    check("w_bus_write", bus_write, 32'hA5);
    check("w_bus_addr", bus_addr, 32'h0000_F000);
    m1_req = 1'b0; m1_wdata = 32'h0000_00FF;
    step();
    check("w_idle_rw", 32'(bus_rw), 32'd0);
    check("w_idle_write", bus_write, 32'd0);
    check("w_idle_len", 32'(bus_len), 32'd0);
    step();
    check("w_done", 32'(m1_done), 32'd1);
    check("w_exc", 32'(m1_exc), 32'd0);
    check("w_m0_done", 32'(m0_done), 32'd0);

    // Both requesting continuously: starvation guard
    m1_rw = 1'b0; m1_addr = 32'h0000_0200; m0_addr = 32'h0000_0300; bus_read = 32'hDEAD_BEEF;
    m0_req = 1'b1; m1_req = 1'b1;
    ng = 0;
    for (int i = 0; i < 18; i++) begin
      step();
      if (m0_gnt || m1_gnt) begin
        if (ng < 6) seq[ng] = {m1_gnt, m0_gnt};
        ng++;
      end
    end
    m0_req = 1'b0; m1_req = 1'b0;
    check("s_count", 32'(ng), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < ng) check($sformatf("s_grant%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
    end
    step();
    step();

    // Illegal length
    m1_req = 1'b1; m1_len = 2'd3; m1_addr = 32'h0000_0123; m1_rw = 1'b0;
    step();
    check("i_gnt", 32'(m1_gnt), 32'd1);
    check("i_bus_addr", bus_addr, 32'd0);
    check("i_bus_rw", 32'(bus_rw), 32'd0);
    m1_req = 1'b0; m1_len = 2'd2;
    step();
    check("i_done", 32'(m1_done), 32'd1);
    check("i_exc", 32'(m1_exc), 32'd1);
    check("i_rdata", m1_rdata, 32'd0);
    step();

    // Bus exception on fetch, then a clean fetch
    m0_req = 1'b1; m0_addr = 32'hFFFF_0000; bus_exception = 1'b1; bus_read = 32'h0;
    step();
    check("e_bus_addr", bus_addr, 32'hFFFF_0000);
    m0_req = 1'b0;
    step();
    step();
    check("e_done", 32'(m0_done), 32'd1);
    check("e_exc", 32'(m0_exc), 32'd1);
    step();
    m0_req = 1'b1; m0_addr = 32'h0000_0400; bus_exception = 1'b0; bus_read = 32'h0BAD_F00D;
    step();
    m0_req = 1'b0;
    step();
    step();
    check("c_done", 32'(m0_done), 32'd1);
    check("c_exc", 32'(m0_exc), 32'd0);
    check("c_rdata", m0_rdata, 32'h0BAD_F00D);
    step();

    // Reset mid-access on the three-wait-state instance
    b_m1_req = 1'b1; m1_rw = 1'b1; m1_len = 2'd2; m1_addr = 32'h0000_0040; m1_wdata = 32'h0000_0055;
    step();
    check("r_gnt", 32'(b_m1_gnt), 32'd1);
    check("r_bus_write", b_bus_write, 32'h55);
    b_m1_req = 1'b0;
    step();
    rst_b = 1'b0;
    #1;
    check("r_async_addr", b_bus_addr, 32'd0);
    check("r_async_write", b_bus_write, 32'd0);
    check("r_async_rw", 32'(b_bus_rw), 32'd0);
    check("r_async_len", 32'(b_bus_len), 32'd0);
    step();
    rst_b = 1'b1;
    b_done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (b_m1_done || b_m0_done) b_done_seen++;
    end
    check("r_no_done", 32'(b_done_seen), 32'd0);

    // Fresh LSU read after reset release
    b_m1_req = 1'b1; m1_rw = 1'b0; m1_addr = 32'h0000_0080; bus_read = 32'hCAFE_F00D;
    step();
    check("n_gnt", 32'(b_m1_gnt), 32'd1);
    check("n_bus_addr0", b_bus_addr, 32'h80);
    b_m1_req = 1'b0;
    step();
    check("n_bus_addr1", b_bus_addr, 32'h80);
    check("n_done1", 32'(b_m1_done), 32'd0);
    step();
    check("n_bus_addr2", b_bus_addr, 32'h80);
    step();
    check("n_bus_idle", b_bus_addr, 32'd0);
    check("n_done3", 32'(b_m1_done), 32'd0);
    step();
    check("n_done4", 32'(b_m1_done), 32'd1);
    check("n_rdata", b_m1_rdata, 32'hCAFE_F00D);
    check("n_exc", 32'(b_m1_exc), 32'd0);
    step();
    check("n_done_pulse", 32'(b_m1_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
